// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a registered 16-bit ALU: buffers commands, issues them in order and returns tagged results.
// Latency: accept at edge n -> res_valid from edge n+3; one command per cycle sustained. Backpressure: issue waits for result-FIFO credits; cmd_ready drops when the command FIFO is full.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 4,
  parameter int TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fun,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      ALU_A,
  output logic [15:0]      ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [31:0]      ALU_OUT,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       res_class,
  output logic             res_div0,
  output logic             res_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RDEPTH);
  localparam logic [3:0]    FUN_IDLE = 4'hF;
  localparam logic [3:0]    FUN_DIV  = 4'd3;
  localparam logic [AW:0]   CMD_ONE  = 1;
  localparam logic [RW:0]   RES_ONE  = 1;
  localparam logic [RW+1:0] CREDITS  = RDEPTH;

  typedef struct packed {
    logic [3:0]       fun;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [3:0]       cls;
    logic             div0;
    logic             illegal;
  } res_t;

  cmd_t             cmd_mem_q [DEPTH];
  cmd_t             cmd_mem_d [DEPTH];
  logic [AW:0]      cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  res_t             res_mem_q [RDEPTH];
  res_t             res_mem_d [RDEPTH];
  logic [RW:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;

  logic [15:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic             v1_q, v1_d, div0_1_q, div0_1_d, ill1_q, ill1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             v2_q, v2_d, div0_2_q, div0_2_d, ill2_q, ill2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [3:0]       cls2_q, cls2_d;

  logic             cmd_full, cmd_empty, push, issue, pop;
  logic [RW:0]      res_count;
  logic [RW+1:0]    credit_use;
  cmd_t             head;
  res_t             res_head, res_new;

  always_comb begin
    cmd_full   = (cmd_wr_q[AW] != cmd_rd_q[AW]) && (cmd_wr_q[AW-1:0] == cmd_rd_q[AW-1:0]);
    cmd_empty  = (cmd_wr_q == cmd_rd_q);
    cmd_ready  = !cmd_full && RST_N;
    push       = cmd_valid && cmd_ready;
    head       = cmd_mem_q[cmd_rd_q[AW-1:0]];
    res_count  = res_wr_q - res_rd_q;
    res_valid  = (res_count != '0);
    pop        = res_valid && res_ready;
    // Every issued op already owns a result slot, so the capture write can never overflow.
    credit_use = {1'b0, res_count} + {{(RW+1){1'b0}}, v1_q} + {{(RW+1){1'b0}}, v2_q}
                 - {{(RW+1){1'b0}}, pop};
    issue      = !cmd_empty && (credit_use < CREDITS);
  end

  always_comb begin
    cmd_mem_d = cmd_mem_q;
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    if (push) begin
      cmd_mem_d[cmd_wr_q[AW-1:0]] = '{fun: cmd_fun, a: cmd_a, b: cmd_b, tag: cmd_tag};
      cmd_wr_d = cmd_wr_q + CMD_ONE;
    end
    if (issue) begin
      cmd_rd_d = cmd_rd_q + CMD_ONE;
    end
  end

  always_comb begin
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = FUN_IDLE;
    v1_d      = 1'b0;
    tag1_d    = tag1_q;
    div0_1_d  = 1'b0;
    ill1_d    = 1'b0;
    if (issue) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_fun_d = head.fun;
      v1_d      = 1'b1;
      tag1_d    = head.tag;
      div0_1_d  = (head.fun == FUN_DIV) && (head.b == 16'd0);
      ill1_d    = (head.fun == FUN_IDLE);
    end
    // Flags follow ALU_FUN, so they are sampled while stage 1 still presents the op.
    v2_d     = v1_q;
    tag2_d   = tag1_q;
    div0_2_d = div0_1_q;
    ill2_d   = ill1_q;
    cls2_d   = {shift_flag, cmp_flag, logic_flag, arith_flag};
  end

  always_comb begin
    res_mem_d       = res_mem_q;
    res_wr_d        = res_wr_q;
    res_rd_d        = res_rd_q;
    res_new.data    = ill2_q ? 32'd0 : (div0_2_q ? 32'hFFFF_FFFF : ALU_OUT);
    res_new.tag     = tag2_q;
    res_new.cls     = cls2_q;
    res_new.div0    = div0_2_q;
    res_new.illegal = ill2_q;
    if (v2_q) begin
      res_mem_d[res_wr_q[RW-1:0]] = res_new;
      res_wr_d = res_wr_q + RES_ONE;
    end
    if (pop) begin
      res_rd_d = res_rd_q + RES_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) cmd_mem_q[i] <= '0;
      for (int i = 0; i < RDEPTH; i++) res_mem_q[i] <= '0;
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= FUN_IDLE;
      v1_q      <= 1'b0;
      tag1_q    <= '0;
      div0_1_q  <= 1'b0;
      ill1_q    <= 1'b0;
      v2_q      <= 1'b0;
      tag2_q    <= '0;
      div0_2_q  <= 1'b0;
      ill2_q    <= 1'b0;
      cls2_q    <= '0;
    end else begin
      cmd_mem_q <= cmd_mem_d;
      res_mem_q <= res_mem_d;
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      v1_q      <= v1_d;
      tag1_q    <= tag1_d;
      div0_1_q  <= div0_1_d;
      ill1_q    <= ill1_d;
      v2_q      <= v2_d;
      tag2_q    <= tag2_d;
      div0_2_q  <= div0_2_d;
      ill2_q    <= ill2_d;
      cls2_q    <= cls2_d;
    end
  end

  always_comb begin
    res_head    = res_mem_q[res_rd_q[RW-1:0]];
    res_data    = res_head.data;
    res_tag     = res_head.tag;
    res_class   = res_head.cls;
    res_div0    = res_head.div0;
    res_illegal = res_head.illegal;
    ALU_A       = alu_a_q;
    ALU_B       = alu_b_q;
    ALU_FUN     = alu_fun_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: registered ALU model plus an in-order expected-result queue built from the command rules.
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_fun = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [31:0] alu_out;
  logic        arith_f, logic_f, cmp_f, shift_f;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [3:0]  res_class;
  logic        res_div0, res_illegal;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_acc = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [3:0]  cls;
    logic        div0;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0]  bb_fun  [4] = '{4'd2, 4'd10, 4'd8, 4'd13};
  logic [15:0] bb_a    [4] = '{16'd300, 16'd5, 16'hFF00, 16'h0001};
  logic [15:0] bb_b    [4] = '{16'd300, 16'd5, 16'h0FF0, 16'd15};
  logic [31:0] bb_data [4] = '{32'd90000, 32'd1, 32'h0000_F0F0, 32'h0000_8001};
  logic [3:0]  bb_cls  [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  alu_cmd_sequencer #(.DEPTH(4), .RDEPTH(4), .TAG_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(alu_out),
    .arith_flag(arith_f), .logic_flag(logic_f), .cmp_flag(cmp_f), .shift_flag(shift_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_class(res_class), .res_div0(res_div0), .res_illegal(res_illegal)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'd0:                      return {16'd0, a} + {16'd0, b};
      4'd1:                      return {16'd0, a} - {16'd0, b};
      4'd2:                      return {16'd0, a} * {16'd0, b};
      4'd3:                      return (b == 16'd0) ? 32'd0 : {16'd0, a / b};
      4'd4, 4'd5, 4'd6, 4'd7:    return {16'd0, a} + {16'd0, b} + {28'd0, f};
      4'd8:                      return {16'd0, a ^ b};
      4'd9:                      return {16'd0, a & b};
      4'd10:                     return {31'd0, a == b};
      4'd11:                     return {31'd0, a < b};
      4'd12:                     return {16'd0, a << b[3:0]};
      4'd13:                     return {16'd0, a ^ (a << b[3:0])};
      4'd14:                     return {16'd0, a >> b[3:0]};
      default:                   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [3:0] cls_of(input logic [3:0] f);
    return {(f >= 4'd12) && (f <= 4'd14), (f == 4'd10) || (f == 4'd11),
            (f == 4'd8) || (f == 4'd9), f < 4'd8};
  endfunction

  // Environment ALU: registered result, class flags decoded straight from ALU_FUN.
  always @(posedge CLK) alu_out <= alu_f(ALU_FUN, ALU_A, ALU_B);
  assign {shift_f, cmp_f, logic_f, arith_f} = cls_of(ALU_FUN);

  function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] tag);
    exp_t e;
    e.div0 = (f == 4'd3) && (b == 16'd0);
    e.ill  = (f == 4'hF);
    e.data = e.ill ? 32'd0 : (e.div0 ? 32'hFFFF_FFFF : alu_f(f, a, b));
    e.tag  = tag;
    e.cls  = cls_of(f);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tag);
    cmd_valid = v;
    cmd_fun   = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  // One clock: score any pop, record any accept, then step to just after the edge.
  task automatic tick(input bit chk_hold = 1'b0);
    bit          acc, pp, hold;
    logic [31:0] hd;
    logic [3:0]  ht;
    exp_t        e;
    acc  = cmd_valid && cmd_ready;
    pp   = res_valid && res_ready;
    hold = res_valid && !res_ready;
    hd   = res_data;
    ht   = res_tag;
    if (pp) begin
      if (exp_q.size() == 0) begin
        check("spurious_res", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_tag", 32'(res_tag), 32'(e.tag));
        check("res_class", 32'(res_class), 32'(e.cls));
        check("res_div0", 32'(res_div0), 32'(e.div0));
        check("res_illegal", 32'(res_illegal), 32'(e.ill));
      end
    end
    if (acc) exp_q.push_back(model(cmd_fun, cmd_a, cmd_b, cmd_tag));
    last_acc = acc;
    @(posedge CLK);
    #1;
    if (chk_hold && hold) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", res_data, hd);
      check("hold_tag", 32'(res_tag), 32'(ht));
    end
  endtask

  task automatic run_one(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [31:0] xd, input logic [3:0] xc,
                         input logic xdiv0, input logic xill);
    int lat;
    res_ready = 1'b1;
    set_cmd(1'b1, f, a, b, tag);
    tick();
    check("one_accept", 32'(last_acc), 32'd1);
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("one_latency", 32'(lat), 32'd3);
    check("one_data", res_data, xd);
    check("one_tag", 32'(res_tag), 32'(tag));
    check("one_class", 32'(res_class), 32'(xc));
    check("one_div0", 32'(res_div0), 32'(xdiv0));
    check("one_illegal", 32'(res_illegal), 32'(xill));
    tick();
    check("one_drained", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int acc_cnt;
    int n;

    // Reset state
    #1 RST_N = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_alu_fun", 32'(ALU_FUN), 32'hF);
    check("rst_alu_a", 32'(ALU_A), 32'd0);
    check("rst_alu_b", 32'(ALU_B), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    check("rst_res_class", 32'(res_class), 32'd0);
    check("rst_res_flags", 32'({res_div0, res_illegal}), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Single add with latency
    run_one(4'd0, 16'h1234, 16'h0101, 4'd5, 32'h0000_1335, 4'b0001, 1'b0, 1'b0);

    // Back-to-back, one per cycle
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, bb_fun[i], bb_a[i], bb_b[i], 4'(i + 1));
      tick();
      check("b2b_accept", 32'(last_acc), 32'd1);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", 32'(res_valid), 32'd1);
      check("b2b_tag", 32'(res_tag), 32'(i + 1));
      check("b2b_data", res_data, bb_data[i]);
      check("b2b_class", 32'(res_class), 32'(bb_cls[i]));
      tick();
    end
    check("b2b_done", 32'(res_valid), 32'd0);

    // Backpressure: DEPTH + RDEPTH accepts then cmd_ready drops
    res_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      set_cmd(1'b1, 4'(acc_cnt), 16'($urandom), 16'($urandom), 4'(acc_cnt));
      tick(1'b1);
      if (last_acc) acc_cnt++;
    end
    check("bp_accepts", 32'(acc_cnt), 32'd8);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_drain_valid", 32'(res_valid), 32'd1);
      check("bp_drain_tag", 32'(res_tag), 32'(i));
      tick();
    end
    check("bp_drain_done", 32'(res_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Divide by zero, normal divide, illegal code
    run_one(4'd3, 16'd100, 16'd0, 4'd6, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b0);
    run_one(4'd3, 16'd100, 16'd7, 4'd7, 32'd14, 4'b0001, 1'b0, 1'b0);
    run_one(4'hF, 16'd1, 16'd1, 4'd8, 32'd0, 4'b0000, 1'b0, 1'b1);

    // Reset mid-stream with work buffered and in flight
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, 4'd0, 16'(i), 16'd1, 4'(i));
      tick();
    end
    cmd_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_fun", 32'(ALU_FUN), 32'hF);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_data", res_data, 32'd0);
    exp_q.delete();
    #1 RST_N = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", 32'(res_valid), 32'd0);
      check("mid_rst_ready_up", 32'(cmd_ready), 32'd1);
    end
    run_one(4'd1, 16'd10, 16'd3, 4'd9, 32'd7, 4'b0001, 1'b0, 1'b0);

    // Randomized traffic against the expected-result queue
    for (int i = 0; i < 400; i++) begin
      set_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 40)),
              4'($urandom_range(0, 15)));
      res_ready = ($urandom_range(0, 3) != 0);
      tick(1'b1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 40) begin
      tick();
      n++;
    end
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rand_res_idle", 32'(res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
